// File: rtl/radix4_online_digit_select_if.sv
// Stream and control bundle for the radix-4 online digit-selection stage.
// The master side drives start/w_in, the x digit stream and p_ready;
// the slave side (the stage) returns the p digit stream and status.
interface radix4_online_digit_select_if #(
  parameter int RADIX_BITS     = 3,
  parameter int NUM_RES_DIGITS = 7
);
  logic                                 start;
  logic [RADIX_BITS*NUM_RES_DIGITS-1:0] w_in;
  logic [RADIX_BITS-1:0]                x_in;
  logic                                 x_valid;
  logic                                 x_ready;
  logic [RADIX_BITS-1:0]                p_out;
  logic                                 p_valid;
  logic                                 p_ready;
  logic [RADIX_BITS*NUM_RES_DIGITS-1:0] w_out;
  logic                                 busy;
  logic                                 done;
  logic                                 ovf;

  modport master (
    output start, w_in, x_in, x_valid, p_ready,
    input  x_ready, p_out, p_valid, w_out, busy, done, ovf
  );

  modport slave (
    input  start, w_in, x_in, x_valid, p_ready,
    output x_ready, p_out, p_valid, w_out, busy, done, ovf
  );
endinterface

// File: rtl/radix4_online_digit_select.sv
// Radix-4 online digit selection and residual update.
// Loads a redundant residual, then for each accepted input digit selects
// an output digit from the two top residual digits, subtracts it, shifts
// the residual up one digit and appends the new input digit.
module radix4_online_digit_select #(
  parameter int no_of_digits = 4,
  parameter int radix_bits   = 3,
  parameter int radix        = 4,
  parameter int delta        = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  radix4_online_digit_select_if.slave  bus
);

  localparam int N  = no_of_digits + delta + 1;   // residual digits
  localparam int CW = $clog2(no_of_digits + 1);   // iteration counter width
  localparam int EW = radix_bits + 4;             // estimate width, with headroom
  localparam int SH = $clog2(radix);              // multiply/divide by radix

  localparam logic signed [EW-1:0] HALF = EW'(radix / 2);
  localparam logic signed [EW-1:0] PMAX = EW'(radix - 1);
  localparam logic signed [EW-1:0] PMIN = EW'(-(radix - 1));
  localparam logic signed [EW-1:0] RMAX = EW'(2 ** (radix_bits - 1) - 1);
  localparam logic signed [EW-1:0] RMIN = EW'(-(2 ** (radix_bits - 1)));
  localparam logic [radix_bits-1:0] X_BAD = {1'b1, {(radix_bits - 1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [radix_bits*N-1:0] w_q, w_d;
  logic [radix_bits-1:0]   p_q, p_d;
  logic                    p_valid_q, p_valid_d;
  logic                    done_q, done_d;
  logic                    ovf_q, ovf_d;

  logic signed [radix_bits-1:0] d_top, d_sub;
  logic signed [EW-1:0]         e, p_raw, p_sel, r;
  logic [radix_bits-1:0]        r_dig;
  logic                         r_ovf;
  logic                         x_ready, fire;

  assign d_top = w_q[radix_bits*N-1 -: radix_bits];
  assign d_sub = w_q[radix_bits*(N-1)-1 -: radix_bits];

  // A new digit may enter only when the output slot is empty or draining.
  assign x_ready = (state_q == RUN) && (!p_valid_q || bus.p_ready);
  assign fire    = x_ready && bus.x_valid;

  // Estimate, rounded digit selection with clamping, and saturated remainder.
  always_comb begin
    e     = (EW'(d_top) <<< SH) + EW'(d_sub);
    p_raw = (e + HALF) >>> SH;
    if (p_raw > PMAX)      p_sel = PMAX;
    else if (p_raw < PMIN) p_sel = PMIN;
    else                   p_sel = p_raw;
    r     = e - (p_sel <<< SH);
    r_ovf = (r > RMAX) || (r < RMIN);
    if (r > RMAX)      r_dig = RMAX[radix_bits-1:0];
    else if (r < RMIN) r_dig = RMIN[radix_bits-1:0];
    else               r_dig = r[radix_bits-1:0];
  end

  // Next-state and datapath update for IDLE / RUN / DONE.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    w_d       = w_q;
    p_d       = p_q;
    p_valid_d = p_valid_q;
    done_d    = 1'b0;
    ovf_d     = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          w_d     = bus.w_in;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (p_valid_q && bus.p_ready) p_valid_d = 1'b0;
        if (fire) begin
          w_d       = {r_dig, w_q[radix_bits*(N-2)-1:0], bus.x_in};
          p_d       = p_sel[radix_bits-1:0];
          p_valid_d = 1'b1;
          cnt_d     = cnt_q + CW'(1);
          if (r_ovf || (bus.x_in == X_BAD)) ovf_d = 1'b1;
          if (cnt_q == CW'(no_of_digits - 1)) state_d = DONE;
        end
      end
      DONE: begin
        if (!p_valid_q || bus.p_ready) begin
          p_valid_d = 1'b0;
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      w_q       <= '0;
      p_q       <= '0;
      p_valid_q <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      w_q       <= w_d;
      p_q       <= p_d;
      p_valid_q <= p_valid_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.x_ready = x_ready;
  assign bus.p_out   = p_q;
  assign bus.p_valid = p_valid_q;
  assign bus.w_out   = w_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;
  assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_radix4_online_digit_select.sv
// Bench for radix4_online_digit_select: integer-arithmetic residual model,
// expectation queue compared on every accepted output digit, directed
// literal cases and randomized operations with random handshakes.
module tb_radix4_online_digit_select;

  localparam int ND = 4;
  localparam int RB = 3;
  localparam int NR = ND + 2 + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  radix4_online_digit_select_if #(.RADIX_BITS(RB), .NUM_RES_DIGITS(NR)) io ();

  radix4_online_digit_select #(
    .no_of_digits(ND), .radix_bits(RB), .radix(4), .delta(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (io)
  );

  typedef struct {
    int               p;
    logic [RB*NR-1:0] w;
    logic             ovf;
  } exp_t;

  exp_t exp_q[$];
  int   got_p[$];
  int   got_top[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   done_cnt = 0;
  int   ready_mode = 0;   // 0: always ready, 1: random, 2: never
  int   md[NR];           // model residual digits, index 0 = least significant
  logic m_ovf;

  int wd1[NR] = '{0, 0, 0, 0, 0, 2, 1};
  int wd2[NR] = '{0, 0, 0, 0, 0, -4, -4};
  int wd3[NR] = '{0, 0, 0, 0, 0, 3, 3};
  int xs0[ND] = '{0, 0, 0, 0};
  int wdr[NR];
  int xsr[ND];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sdig(input logic [RB-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic int fdiv4(input int a);
    return (a >= 0) ? a / 4 : -((-a + 3) / 4);
  endfunction

  function automatic logic [RB*NR-1:0] pack_w();
    logic [RB*NR-1:0] w;
    int t;
    w = '0;
    for (int i = 0; i < NR; i++) begin
      t = md[i];
      w[RB*i +: RB] = t[RB-1:0];
    end
    return w;
  endfunction

  // One online iteration computed with plain integer arithmetic.
  task automatic model_fire(input int x);
    int e, p, r;
    exp_t ent;
    e = 4 * md[NR-1] + md[NR-2];
    p = fdiv4(e + 2);
    if (p > 3) p = 3;
    if (p < -3) p = -3;
    r = e - 4 * p;
    if (r > 3) begin r = 3; m_ovf = 1'b1; end
    else if (r < -4) begin r = -4; m_ovf = 1'b1; end
    if (x == -4) m_ovf = 1'b1;
    for (int i = NR - 2; i >= 1; i--) md[i] = md[i-1];
    md[0] = x;
    md[NR-1] = r;
    ent.p = p;
    ent.w = pack_w();
    ent.ovf = m_ovf;
    exp_q.push_back(ent);
  endtask

  // Downstream ready generator.
  initial begin
    io.p_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       io.p_ready = 1'b1;
        1:       io.p_ready = 1'($urandom_range(0, 1));
        default: io.p_ready = 1'b0;
      endcase
    end
  end

  // Compare process: every accepted digit against the model queue.
  initial begin
    exp_t ex;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if (io.x_ready) check("x_ready_implies_busy", io.busy, 1);
        if (io.p_valid && io.p_ready) begin
          check("digit_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            ex = exp_q.pop_front();
            check("p_out", sdig(io.p_out), ex.p);
            check("w_out", io.w_out, ex.w);
            check("ovf", io.ovf, ex.ovf);
            got_p.push_back(sdig(io.p_out));
            got_top.push_back(sdig(io.w_out[RB*NR-1 -: RB]));
          end
        end
        if (io.done) begin
          done_cnt++;
          check("done_busy_low", io.busy, 0);
          check("done_p_valid_low", io.p_valid, 0);
        end
      end
    end
  end

  // One operation: load, feed ND digits, optional stall / start glitch / abort.
  task automatic run_op(input int wd[NR], input int xs[ND], input int mode,
                        input int stall, input bit glitch, input int abort_at);
    int k, budget, d0;
    logic [RB-1:0]    sp;
    logic [RB*NR-1:0] sw;
    got_p.delete();
    got_top.delete();
    exp_q.delete();
    d0 = done_cnt;
    @(negedge clk);
    for (int i = 0; i < NR; i++) md[i] = wd[i];
    m_ovf = 1'b0;
    io.w_in = pack_w();
    io.start = 1'b1;
    ready_mode = (stall > 0) ? 2 : mode;
    @(negedge clk);
    io.start = 1'b0;
    io.w_in = RB*NR'($urandom);
    #2;
    check("start_busy", io.busy, 1);
    check("start_ovf_clear", io.ovf, 0);
    check("start_w_loaded", io.w_out, pack_w());
    k = 0;
    budget = 0;
    while (k < ND) begin
      @(negedge clk);
      if (glitch && k == 1) begin
        io.start = 1'b1;
        io.w_in = RB*NR'($urandom);
      end else io.start = 1'b0;
      io.x_valid = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      io.x_in = xs[k][RB-1:0];
      #1;
      if (io.x_valid && io.x_ready) begin
        model_fire(xs[k]);
        k++;
        if (abort_at != 0 && k == abort_at) begin
          @(posedge clk);
          #2;
          rst_n = 1'b0;
          io.x_valid = 1'b0;
          #1;
          check("abort_p_out", io.p_out, 0);
          check("abort_p_valid", io.p_valid, 0);
          check("abort_x_ready", io.x_ready, 0);
          check("abort_busy", io.busy, 0);
          check("abort_done", io.done, 0);
          check("abort_ovf", io.ovf, 0);
          check("abort_w_out", io.w_out, 0);
          exp_q.delete();
          @(negedge clk);
          rst_n = 1'b1;
          return;
        end
        if (k == 1 && stall > 0) begin
          @(negedge clk);
          io.x_valid = 1'b1;
          io.x_in = xs[1][RB-1:0];
          #1;
          check("stall_p_valid", io.p_valid, 1);
          sp = io.p_out;
          sw = io.w_out;
          for (int c = 0; c < stall; c++) begin
            @(negedge clk);
            #1;
            check("stall_x_ready_low", io.x_ready, 0);
            check("stall_p_held", io.p_out, sp);
            check("stall_w_frozen", io.w_out, sw);
          end
          ready_mode = mode;
        end
      end
      budget++;
      if (budget > 500) begin
        check("x_handshake_timeout", k, ND);
        break;
      end
    end
    @(negedge clk);
    io.x_valid = 1'b0;
    io.start = 1'b0;
    budget = 0;
    while (done_cnt == d0 && budget < 300) begin
      @(negedge clk);
      #3;
      budget++;
    end
    check("done_seen", done_cnt - d0, 1);
    io.x_valid = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    check("done_single_pulse", done_cnt - d0, 1);
    check("idle_x_ready_low", io.x_ready, 0);
    check("idle_busy_low", io.busy, 0);
    check("queue_drained", exp_q.size(), 0);
    check("ovf_sticky", io.ovf, m_ovf);
    io.x_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    io.start = 1'b0;
    io.w_in = '0;
    io.x_in = '0;
    io.x_valid = 1'b0;

    // Reset with inputs toggling.
    ready_mode = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      io.start = 1'($urandom_range(0, 1));
      io.w_in = RB*NR'($urandom);
      io.x_in = RB'($urandom);
      io.x_valid = 1'b1;
      #1;
      check("rst_p_out", io.p_out, 0);
      check("rst_p_valid", io.p_valid, 0);
      check("rst_x_ready", io.x_ready, 0);
      check("rst_busy", io.busy, 0);
      check("rst_done", io.done, 0);
      check("rst_ovf", io.ovf, 0);
      check("rst_w_out", io.w_out, 0);
    end
    @(negedge clk);
    io.start = 1'b0;
    io.x_valid = 1'b0;
    rst_n = 1'b1;

    // d6=1, d5=2: digits 2,-2,0,0.
    run_op(wd1, xs0, 0, 0, 1'b0, 0);
    check("dir1_count", got_p.size(), 4);
    if (got_p.size() == 4) begin
      check("dir1_p0", got_p[0], 2);
      check("dir1_top0", got_top[0], -2);
      check("dir1_p1", got_p[1], -2);
      check("dir1_top1", got_top[1], 0);
      check("dir1_p2", got_p[2], 0);
      check("dir1_p3", got_p[3], 0);
    end
    check("dir1_ovf", io.ovf, 0);

    // d6=-4, d5=-4: clamped digit, saturated remainder, sticky ovf.
    run_op(wd2, xs0, 0, 0, 1'b0, 0);
    check("dir2_count", got_p.size(), 4);
    if (got_p.size() == 4) begin
      check("dir2_p0", got_p[0], -3);
      check("dir2_top0", got_top[0], -4);
      check("dir2_p1", got_p[1], -3);
    end
    repeat (2) @(negedge clk);
    check("dir2_ovf_held", io.ovf, 1);

    // d6=3, d5=3: clamped to 3, remainder fits.
    run_op(wd3, xs0, 0, 0, 1'b0, 0);
    check("dir3_count", got_p.size(), 4);
    if (got_p.size() == 4) begin
      check("dir3_p0", got_p[0], 3);
      check("dir3_top0", got_top[0], 3);
      check("dir3_p1", got_p[1], 3);
      check("dir3_top1", got_top[1], 0);
    end
    check("dir3_ovf", io.ovf, 0);

    // Backpressure after the first digit.
    for (int i = 0; i < NR; i++) wdr[i] = int'($urandom_range(0, 7)) - 4;
    for (int i = 0; i < ND; i++) xsr[i] = int'($urandom_range(0, 6)) - 3;
    run_op(wdr, xsr, 0, 5, 1'b0, 0);
    check("stall_count", got_p.size(), 4);

    // start during RUN is ignored.
    run_op(wd1, xs0, 0, 0, 1'b1, 0);
    check("glitch_count", got_p.size(), 4);
    if (got_p.size() == 4) begin
      check("glitch_p0", got_p[0], 2);
      check("glitch_p1", got_p[1], -2);
    end

    // Reset mid-iteration 2, then a clean operation.
    run_op(wd1, xs0, 0, 0, 1'b0, 2);
    run_op(wd1, xs0, 0, 0, 1'b0, 0);
    check("post_abort_count", got_p.size(), 4);

    // Randomized operations with random handshakes.
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < NR; i++) wdr[i] = int'($urandom_range(0, 7)) - 4;
      for (int i = 0; i < ND; i++)
        xsr[i] = ($urandom_range(0, 7) == 0) ? -4 : int'($urandom_range(0, 6)) - 3;
      run_op(wdr, xsr, 1, 0, 1'b0, 0);
      check("rand_count", got_p.size(), 4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/radix4_online_digit_select.md
Name: radix4_online_digit_select

Overview:
- Sequential digit-selection and residual-update stage for the radix-4 online datapath.
- Sits directly downstream of the residual modification stage. It loads the modified redundant residual vector, then performs one iteration per accepted online input digit.
- Each iteration selects an output digit from the two most significant residual digits, subtracts it, scales the residual by radix and appends the new input digit.
- Output digits are emitted on a valid/ready stream, most significant first.

Parameters:
- no_of_digits, 4, number of iterations, which is also the number of output digits per operation.
- radix_bits, 3, bits per signed digit (two's complement).
- radix, 4, radix; fixed at 4 for this block.
- delta, 2, online delay; sets the residual width only.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; loads w_in; honoured only in IDLE.
- w_in  input  radix_bits*(no_of_digits+delta+1)  modified residual; digit i at bits [radix_bits*(i+1)-1 : radix_bits*i]; digit N-1 (N=no_of_digits+delta+1) has weight 1, digit N-2 has weight 1/4, and so on.
- x_in  input  radix_bits  online input digit, legal range [-3,3].
- x_valid  input  1  x_in valid.
- x_ready  output  1  stage accepts x_in this cycle.
- p_out  output  radix_bits  selected output digit, range [-3,3].
- p_valid  output  1  p_out valid.
- p_ready  input  1  downstream accepts p_out.
- w_out  output  radix_bits*N  current residual register.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse after the last digit is accepted downstream.
- ovf  output  1  sticky error flag.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, residual=0, iteration counter=0.
  - p_out=0, p_valid=0, x_ready=0, busy=0, done=0, ovf=0.
- IDLE:
  - start=1 -> residual<=w_in, counter<=0, ovf<=0, go to RUN (busy=1 next cycle).
  - start in any other state is ignored.
- RUN:
  - x_ready = (!p_valid || p_ready).
  - An iteration fires on x_valid && x_ready.
  - Estimate e = 4*d[N-1] + d[N-2] (signed integer, range [-20,15]).
  - Select p = floor((e+2)/4), then clamp to [-3,3].
  - Update r = e - 4p. New residual:
    - d'[N-1] = r
    - d'[i] = d[i-1] for i in 1..N-2
    - d'[0] = x_in
  - If r is outside [-4,3]: d'[N-1] saturates to -4 or 3, and ovf<=1.
  - If x_in == -4: ovf<=1 and the digit is still shifted in.
  - Output register: p_out<=p, p_valid<=1 in the same edge as the residual update.
  - Iteration latency is one cycle: p_out appears the cycle after the handshake.
  - p_valid stays high with p_out stable until p_ready. A simultaneous p_ready and new iteration replaces it with no bubble.
  - The counter increments per iteration. When it reaches no_of_digits, go to DONE and deassert x_ready.
- DONE:
  - Wait until the final p_out is accepted (p_valid && p_ready, or p_valid already 0).
  - Then pulse done for one cycle, clear busy, return to IDLE.
- Without an accepting p_ready, the stall is indefinite; residual and counter hold.
- x_valid while not in RUN: ignored, no state change.
- Reset mid-operation: immediate return to reset values; the partial result is discarded.
- ovf clears only on reset or on an accepted start.

Test Plan:
- Reset with all inputs toggling -> every output 0 and state IDLE; x_ready stays 0 while x_valid=1.
- Load w_in with d6=1, d5=2, rest 0; feed x_in=0 x4 with p_ready=1:
  - first p_out=2 and d'[6]=-2
  - second: e=-8 -> p_out=-2, d'[6]=0
  - remaining p_out=0, 0
  - done pulses once, ovf=0.
- Load d6=-4, d5=-4: e=-20, p clamped to -3, r=-8 -> p_out=-3, d'[6]=-4, ovf=1 and it stays 1 until the next start.
- Load d6=3, d5=3: e=15 -> p_out=3 (clamped), r=3 fits, ovf=0.
- Backpressure: hold p_ready=0 after the first digit -> x_ready=0, p_out held stable and the residual frozen for 5 cycles. Release -> remaining digits are emitted with no loss or duplication.
- Edge cases:
  - start asserted during RUN -> ignored.
  - rst_n pulsed low mid-iteration 2 -> all outputs 0 immediately.
  - a fresh start afterwards completes normally with 4 digits.
